// File: rtl/jh_external_single_port_ram.sv
// rtl/jh_external_single_port_ram.sv - single-port RAM, shared address, 2-cycle registered read
// Stage 1 captures the address, stage 2 reads the array into dout; writes commit on the edge.
module jh_external_single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] dout
);

  // One extra bit so the bound compare also works when RAM_DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ok;
  logic                  rd_ok;

  always_comb begin
    wr_ok  = wr_en && !rst && ({1'b0, addr} < DEPTH_LIMIT);
    rd_ok  = {1'b0, addr_q} < DEPTH_LIMIT;
    addr_d = rst ? '0 : addr;
    dout_d = '0;
    // Array read sees only writes from earlier edges, giving read-first ordering.
    if (!rst && rd_ok) begin
      dout_d = mem_q[addr_q];
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    dout_q <= dout_d;
    if (wr_ok) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_jh_external_single_port_ram.sv
// tb/tb_jh_external_single_port_ram.sv - scoreboard bench for jh_external_single_port_ram
// Drives a 256-deep and a 200-deep instance with identical stimulus and checks both.
module tb_jh_external_single_port_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] addr;
  logic       wr_en;
  logic [7:0] dout256;
  logic [7:0] dout200;

  always #5 clk = ~clk;

  jh_external_single_port_ram #(.DATA_WIDTH(8), .RAM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .dout(dout256)
  );

  jh_external_single_port_ram #(.DATA_WIDTH(8), .RAM_DEPTH(200)) dut200 (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .dout(dout200)
  );

  // Reference: plain arrays plus the word each device will present if the next edge is not a reset.
  logic [7:0] m256 [256];
  logic [7:0] m200 [256];
  logic [7:0] p256 = 8'h00;
  logic [7:0] p200 = 8'h00;
  logic [7:0] q256 [$];
  logic [7:0] q200 [$];
  logic [7:0] fill [256];

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      m256[i] = 8'h00;
      m200[i] = 8'h00;
    end
  end

  // Inputs for one edge; pushes the dout expected right after that edge.
  task automatic drive(input logic r, input logic [7:0] a, input logic w, input logic [7:0] d);
    rst   = r;
    addr  = a;
    wr_en = w;
    din   = d;
    q256.push_back(r ? 8'h00 : p256);
    q200.push_back(r ? 8'h00 : p200);
    if (!r && w) begin
      m256[a] = d;
      if (a < 8'd200) m200[a] = d;
    end
    p256 = r ? m256[0] : m256[a];
    p200 = r ? m200[0] : ((a < 8'd200) ? m200[a] : 8'h00);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge clk);
      @(negedge clk);
      if (q256.size() != 0) begin
        e = q256.pop_front();
        tests++;
        if (dout256 !== e) begin
          fails++;
          $display("FAIL dout_d256 edge %0d: got %h expected %h", edge_no, dout256, e);
        end
      end
      if (q200.size() != 0) begin
        e = q200.pop_front();
        tests++;
        if (dout200 !== e) begin
          fails++;
          $display("FAIL dout_d200 edge %0d: got %h expected %h", edge_no, dout200, e);
        end
      end
      edge_no++;
    end
  end

  initial begin : stimulus
    // Reset held with addr=5, then release and hold the address.
    drive(1'b1, 8'd5, 1'b0, 8'h00);
    drive(1'b1, 8'd5, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 8'd5, 1'b0, 8'h00);

    // Write during reset must be ignored.
    drive(1'b1, 8'd7, 1'b1, 8'hFF);
    repeat (3) drive(1'b0, 8'd7, 1'b0, 8'h00);

    // Fill all addresses, then read each one back for three cycles.
    for (int i = 0; i < 256; i++) begin
      fill[i] = 8'($urandom);
      drive(1'b0, 8'(i), 1'b1, fill[i]);
    end
    for (int i = 0; i < 256; i++) begin
      repeat (3) drive(1'b0, 8'(i), 1'b0, 8'h00);
    end

    // Streaming reads, one new address per cycle.
    for (int i = 0; i < 256; i++) drive(1'b0, 8'(i), 1'b0, 8'h00);

    // Read-after-write on the same address, then overwrite.
    drive(1'b0, 8'd10, 1'b1, 8'hA5);
    repeat (2) drive(1'b0, 8'd10, 1'b0, 8'h00);
    drive(1'b0, 8'd10, 1'b1, 8'h3C);
    repeat (2) drive(1'b0, 8'd10, 1'b0, 8'h00);

    // Reset in the middle of streaming reads; contents must survive.
    for (int i = 20; i < 30; i++) drive((i == 24) || (i == 25), 8'(i), 1'b0, 8'h00);
    for (int i = 20; i < 30; i++) drive(1'b0, 8'(i), 1'b0, 8'h00);

    // Depth boundary: 210 is out of range for the 200-deep instance, 199 is the last word.
    drive(1'b0, 8'd210, 1'b1, 8'h55);
    repeat (3) drive(1'b0, 8'd210, 1'b0, 8'h00);
    drive(1'b0, 8'd199, 1'b1, 8'h9E);
    repeat (3) drive(1'b0, 8'd199, 1'b0, 8'h00);
    drive(1'b0, 8'd200, 1'b0, 8'h00);
    drive(1'b0, 8'd255, 1'b0, 8'h00);
    drive(1'b0, 8'd0, 1'b0, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 31) == 0), 8'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom));
    end

    #1;
    tests++;
    if ((q256.size() != 0) || (q200.size() != 0)) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q256.size(), q200.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
